// File: rtl/fxp_div.sv
// ============================================================================
// Module   : fxp_div
// Purpose  : Sequential signed fixed-point divider. One restoring
//            shift-subtract quotient bit per clock. Reports saturation,
//            underflow and divide-by-zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fxp_div #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_WIDTH = 14,
    parameter int INT_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] A_in,
    input  logic [DATA_WIDTH-1:0] B_in,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  overflow_flag,
    output logic                  underflow_flag,
    output logic                  div_by_zero_flag
);

    localparam int N  = DATA_WIDTH + FRAC_WIDTH;
    localparam int CW = $clog2(N + 1);

    // Largest positive magnitude; one more is still exact for a negative result.
    localparam logic [N-1:0] POS_LIMIT = N'((64'd1 << (INT_WIDTH + FRAC_WIDTH - 1)) - 64'd1);
    localparam logic [N-1:0] NEG_LIMIT = POS_LIMIT + N'(1);
    localparam logic [DATA_WIDTH-1:0] MAX_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_DIV  = 1'b1
    } state_t;

    state_t                state, state_nx;
    logic [CW-1:0]         count, count_nx;
    logic [N-1:0]          num, num_nx;
    logic [N-1:0]          quot, quot_nx;
    logic [DATA_WIDTH:0]   rem, rem_nx;
    logic [DATA_WIDTH-1:0] divisor, divisor_nx;
    logic                  sign, sign_nx;
    logic                  a_nonzero, a_nonzero_nx;
    logic [DATA_WIDTH-1:0] out_nx;
    logic                  ovf_nx, udf_nx, dbz_nx, done_nx;

    logic [DATA_WIDTH-1:0] abs_a, abs_b, neg_q;
    logic [DATA_WIDTH+1:0] rem_shift;
    logic [DATA_WIDTH:0]   rem_diff;
    logic                  q_bit;
    logic [N-1:0]          quot_shift;

    assign busy = (state == S_DIV);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            count            <= '0;
            num              <= '0;
            quot             <= '0;
            rem              <= '0;
            divisor          <= '0;
            sign             <= 1'b0;
            a_nonzero        <= 1'b0;
            out              <= '0;
            overflow_flag    <= 1'b0;
            underflow_flag   <= 1'b0;
            div_by_zero_flag <= 1'b0;
            done             <= 1'b0;
        end else begin
            state            <= state_nx;
            count            <= count_nx;
            num              <= num_nx;
            quot             <= quot_nx;
            rem              <= rem_nx;
            divisor          <= divisor_nx;
            sign             <= sign_nx;
            a_nonzero        <= a_nonzero_nx;
            out              <= out_nx;
            overflow_flag    <= ovf_nx;
            underflow_flag   <= udf_nx;
            div_by_zero_flag <= dbz_nx;
            done             <= done_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        count_nx     = count;
        num_nx       = num;
        quot_nx      = quot;
        rem_nx       = rem;
        divisor_nx   = divisor;
        sign_nx      = sign;
        a_nonzero_nx = a_nonzero;
        out_nx       = out;
        ovf_nx       = overflow_flag;
        udf_nx       = underflow_flag;
        dbz_nx       = div_by_zero_flag;
        done_nx      = 1'b0;

        // Negating 0x8000 yields 0x8000, which is the correct unsigned magnitude.
        abs_a      = A_in[DATA_WIDTH-1] ? -A_in : A_in;
        abs_b      = B_in[DATA_WIDTH-1] ? -B_in : B_in;
        rem_shift  = {rem, num[N-1]};
        q_bit      = (rem_shift >= {2'b00, divisor});
        rem_diff   = rem_shift[DATA_WIDTH:0] - {1'b0, divisor};
        quot_shift = {quot[N-2:0], q_bit};
        neg_q      = -quot_shift[DATA_WIDTH-1:0];

        case (state)
            S_IDLE: begin
                if (start) begin
                    if (B_in == '0) begin
                        done_nx = 1'b1;
                        out_nx  = A_in[DATA_WIDTH-1] ? MIN_NEG : MAX_POS;
                        ovf_nx  = 1'b1;
                        udf_nx  = 1'b0;
                        dbz_nx  = 1'b1;
                    end else begin
                        state_nx     = S_DIV;
                        count_nx     = CW'(N);
                        num_nx       = {abs_a, {FRAC_WIDTH{1'b0}}};
                        divisor_nx   = abs_b;
                        sign_nx      = A_in[DATA_WIDTH-1] ^ B_in[DATA_WIDTH-1];
                        a_nonzero_nx = |A_in;
                        quot_nx      = '0;
                        rem_nx       = '0;
                    end
                end
            end
            S_DIV: begin
                num_nx   = {num[N-2:0], 1'b0};
                quot_nx  = quot_shift;
                rem_nx   = q_bit ? rem_diff : rem_shift[DATA_WIDTH:0];
                count_nx = count - CW'(1);
                if (count == CW'(1)) begin
                    state_nx = S_IDLE;
                    done_nx  = 1'b1;
                    ovf_nx   = 1'b0;
                    udf_nx   = 1'b0;
                    dbz_nx   = 1'b0;
                    if (!sign && (quot_shift > POS_LIMIT)) begin
                        out_nx = MAX_POS;
                        ovf_nx = 1'b1;
                    end else if (sign && (quot_shift > NEG_LIMIT)) begin
                        out_nx = MIN_NEG;
                        ovf_nx = 1'b1;
                    end else if (a_nonzero && (quot_shift == '0)) begin
                        out_nx = '0;
                        udf_nx = 1'b1;
                    end else begin
                        out_nx = sign ? neg_q : quot_shift[DATA_WIDTH-1:0];
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_fxp_div.sv
// ============================================================================
// Module   : tb_fxp_div
// Purpose  : Self-checking bench for fxp_div against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fxp_div;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] a_in, b_in;
    logic        busy, done, ovf, udf, dbz;
    logic [15:0] q_out;

    int total  = 0;
    int passed = 0;
    int failed = 0;
    int edges  = 0;

    fxp_div dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .A_in             (a_in),
        .B_in             (b_in),
        .busy             (busy),
        .done             (done),
        .out              (q_out),
        .overflow_flag    (ovf),
        .underflow_flag   (udf),
        .div_by_zero_flag (dbz)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        edges++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Exact real-number quotient scaled by 2^14, truncated toward zero, then clamped.
    task automatic ref_div(input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] eo, output logic eov,
                           output logic eud, output logic edz, output int elat);
        longint sa, sb, q;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        eov = 1'b0; eud = 1'b0; edz = 1'b0;
        if (sb == 0) begin
            edz = 1'b1; eov = 1'b1; elat = 0;
            eo = (sa < 0) ? 16'h8000 : 16'h7FFF;
        end else begin
            elat = 30;
            q = (sa * 16384) / sb;
            if (q > 32767) begin
                eo = 16'h7FFF; eov = 1'b1;
            end else if (q < -32768) begin
                eo = 16'h8000; eov = 1'b1;
            end else begin
                eo  = 16'(q);
                eud = (sa != 0) && (q == 0);
            end
        end
    endtask

    task automatic launch(input logic [15:0] a, input logic [15:0] b);
        start = 1'b1; a_in = a; b_in = b;
        step();
        edges = 0;
        start = 1'b0;
        a_in = 16'($urandom);
        b_in = 16'($urandom);
    endtask

    task automatic wait_done(input int max_edges);
        while (done !== 1'b1 && edges < max_edges) step();
    endtask

    task automatic check_result(input string tag, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] eo;
        logic eov, eud, edz;
        int elat;
        ref_div(a, b, eo, eov, eud, edz, elat);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_latency"}, 32'(edges), 32'(elat));
        chk({tag, "_out"}, 32'(q_out), 32'(eo));
        chk({tag, "_flags"}, {29'd0, ovf, udf, dbz}, {29'd0, eov, eud, edz});
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic run_check(input string tag, input logic [15:0] a, input logic [15:0] b);
        launch(a, b);
        wait_done(45);
        check_result(tag, a, b);
        step();
        chk({tag, "_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int seen;
        logic [15:0] ra, rb;

        rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0;
        repeat (3) step();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_out", 32'(q_out), 32'd0);
        chk("reset_flags", {29'd0, ovf, udf, dbz}, 32'd0);
        rst_n = 1'b1;

        run_check("quarter_div", 16'h1000, 16'h3000);
        run_check("neg_trunc", 16'hF000, 16'h3000);
        run_check("pos_ovf", 16'h4000, 16'h2000);
        run_check("neg_exact_min", 16'hC000, 16'h2000);
        run_check("neg_divisor", 16'h3000, 16'hA000);
        run_check("min_by_min", 16'h8000, 16'h8000);
        run_check("underflow", 16'h0001, 16'h7FFF);
        run_check("zero_num", 16'h0000, 16'h4000);
        run_check("dbz_pos", 16'h4000, 16'h0000);
        run_check("dbz_neg", 16'hC000, 16'h0000);
        run_check("dbz_zero", 16'h0000, 16'h0000);

        // Start pulse during DIV must be ignored and outputs must hold.
        run_check("pre_ignore", 16'h4000, 16'h2000);
        launch(16'h3000, 16'hA000);
        repeat (5) step();
        start = 1'b1; a_in = 16'h4000; b_in = 16'h0000;
        step();
        start = 1'b0;
        chk("ignore_no_done", 32'(done), 32'd0);
        chk("ignore_out_hold", 32'(q_out), 32'h7FFF);
        chk("ignore_flag_hold", {29'd0, ovf, udf, dbz}, 32'b100);
        wait_done(45);
        check_result("ignore_result", 16'h3000, 16'hA000);
        step();

        // Reset in the middle of a division.
        launch(16'h1000, 16'h3000);
        repeat (9) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_out", 32'(q_out), 32'd0);
        chk("midrst_flags", {30'd0, done, ovf | udf | dbz}, 32'd0);
        seen = 0;
        repeat (35) begin
            step();
            if (done === 1'b1) seen++;
        end
        chk("midrst_no_done", 32'(seen), 32'd0);
        run_check("after_rst", 16'h2000, 16'h6000);

        // Back-to-back: start in the done cycle is accepted.
        launch(16'h1000, 16'h3000);
        wait_done(45);
        check_result("b2b_first", 16'h1000, 16'h3000);
        launch(16'hF000, 16'h3000);
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_pulse", 32'(done), 32'd0);
        wait_done(45);
        check_result("b2b_second", 16'hF000, 16'h3000);
        step();

        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 7))
                0: rb = 16'h0000;
                1: rb = 16'($urandom_range(1, 255));
                2: rb = -16'($urandom_range(1, 255));
                3: ra = 16'($urandom_range(0, 7)) - 16'd4;
                default: rb = 16'($urandom);
            endcase
            if (i % 8 == 3) rb = 16'($urandom);
            run_check($sformatf("rand%0d", i), ra, rb);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
